// File: rtl/kcpsm_io_hub_pkg.sv
// Shared port map and interrupt state encoding for the KCPSM6 I/O hub.
package kcpsm_io_hub_pkg;

  // Read ports
  localparam logic [7:0] PA_BTNS    = 8'h00;
  localparam logic [7:0] PA_SW_LO   = 8'h01;
  localparam logic [7:0] PA_SW_HI   = 8'h02;
  localparam logic [7:0] PA_SYSREG0 = 8'h03;
  localparam logic [7:0] PA_STATUS  = 8'h0E;
  localparam logic [7:0] PA_OVERRUN = 8'h0F;

  // Write ports
  localparam logic [7:0] PA_LED_LO  = 8'h01;
  localparam logic [7:0] PA_LED_HI  = 8'h02;
  localparam logic [7:0] PA_MOTCTL  = 8'h09;
  localparam logic [7:0] PA_DIG0    = 8'h10;
  localparam logic [7:0] PA_DP      = 8'h18;
  localparam logic [7:0] PA_CLEAR   = 8'h1F;

  typedef enum logic {
    IRQ_IDLE = 1'b0,
    IRQ_PEND = 1'b1
  } irq_state_e;

  typedef struct packed {
    logic       en;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_req_t;

endpackage

// File: rtl/kcpsm_io_hub_irq.sv
// Interrupt request/ack FSM with saturating overrun count.
// Optional ack watchdog built when IO_WATCHDOG_EN is defined.
module kcpsm_io_hub_irq
  import kcpsm_io_hub_pkg::*;
#(
  parameter int WDOG_CYCLES = 1000000
) (
  input  logic       sysclk,
  input  logic       sysreset,
  input  logic       upd,
  input  logic       ack,
  input  logic       clr,
  output logic       interrupt,
  output logic [7:0] overrun,
  output logic       wdog_trip
);

  irq_state_e state_q;

  always_ff @(posedge sysclk) begin
    if (!sysreset) begin
      state_q   <= IRQ_IDLE;
      interrupt <= 1'b0;
      overrun   <= '0;
    end else begin
      case (state_q)
        IRQ_IDLE: if (upd) begin
          state_q   <= IRQ_PEND;
          interrupt <= 1'b1;
        end
        IRQ_PEND: begin
          // a fresh event arriving with the ack re-arms the request
          if (ack && !upd) begin
            state_q   <= IRQ_IDLE;
            interrupt <= 1'b0;
          end else if (upd && !ack && overrun != 8'hFF) begin
            overrun <= overrun + 8'd1;
          end
        end
        default: begin
          state_q   <= IRQ_IDLE;
          interrupt <= 1'b0;
        end
      endcase
      if (clr) overrun <= '0;
    end
  end

`ifdef IO_WATCHDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  logic [CW-1:0] wd_cnt;

  always_ff @(posedge sysclk) begin
    if (!sysreset) begin
      wd_cnt    <= '0;
      wdog_trip <= 1'b0;
    end else begin
      if (clr) wdog_trip <= 1'b0;
      if (state_q == IRQ_PEND) begin
        if (wd_cnt == CW'(WDOG_CYCLES - 1)) begin
          wd_cnt    <= '0;
          wdog_trip <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end else begin
        wd_cnt <= '0;
      end
    end
  end
`else
  localparam int unused_wdog_cycles = WDOG_CYCLES;
  assign wdog_trip = 1'b0;
`endif

endmodule

// File: rtl/kcpsm_io_hub.sv
// KCPSM6 port-mapped register hub: buttons/switches/sysreg snapshot in, LEDs/7-seg/motor out.
// Define IO_WATCHDOG_EN to build the interrupt-ack watchdog that parks the motors.
module kcpsm_io_hub
  import kcpsm_io_hub_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int DIGIT_W     = 5,
  parameter int NUM_SYSREGS = 6,
  parameter int LED_W       = 16,
  parameter int SW_W        = 16,
  parameter int BTN_W       = 6,
  parameter int WDOG_CYCLES = 1000000
) (
  input  logic                          sysclk,
  input  logic                          sysreset,
  input  logic [BTN_W-1:0]              dbbtns,
  input  logic [SW_W-1:0]               switches,
  input  logic [7:0]                    port_id,
  input  logic [7:0]                    io_data_in,
  input  logic                          write_strobe,
  input  logic                          k_write_strobe,
  input  logic                          read_strobe,
  output logic [7:0]                    io_data_out,
  output logic                          interrupt,
  input  logic                          interrupt_ack,
  input  logic [NUM_SYSREGS*8-1:0]      sysregs_in,
  input  logic                          upd_sysregs,
  output logic [7:0]                    motctl,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  output logic [NUM_DIGITS-1:0]         dp,
  output logic [LED_W-1:0]              leds
);

  wr_req_t                                wr;
  logic                                   clr;
  logic [7:0]                             overrun;
  logic                                   wdog_trip;
  logic [7:0]                             rd_mux;
  logic [15:0]                            sw_ext;
  logic [7:0]                             btn_ext;
  logic [NUM_SYSREGS-1:0][7:0]            snap_q;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]     dig_q;
  logic                                   unused_read_strobe;

  // Reads have no side effects, so the INPUT strobe carries no information here.
  assign unused_read_strobe = read_strobe;

  // OUTPUTK only carries a 4-bit port, so it can never reach 0x10-0x1F.
  always_comb begin
    wr      = '0;
    wr.data = io_data_in;
    if (write_strobe) begin
      wr.en   = 1'b1;
      wr.addr = port_id;
    end else if (k_write_strobe) begin
      wr.en   = 1'b1;
      wr.addr = {4'h0, port_id[3:0]};
    end
  end

  assign clr = wr.en && (wr.addr == PA_CLEAR);

  kcpsm_io_hub_irq #(.WDOG_CYCLES(WDOG_CYCLES)) u_irq (
    .sysclk    (sysclk),
    .sysreset  (sysreset),
    .upd       (upd_sysregs),
    .ack       (interrupt_ack),
    .clr       (clr),
    .interrupt (interrupt),
    .overrun   (overrun),
    .wdog_trip (wdog_trip)
  );

  always_comb begin
    sw_ext              = '0;
    sw_ext[SW_W-1:0]    = switches;
    btn_ext             = '0;
    btn_ext[BTN_W-1:0]  = dbbtns;
    rd_mux              = '0;
    case (port_id)
      PA_BTNS:    rd_mux = btn_ext;
      PA_SW_LO:   rd_mux = sw_ext[7:0];
      PA_SW_HI:   rd_mux = sw_ext[15:8];
      PA_STATUS:  rd_mux = {6'b0, wdog_trip, |overrun};
      PA_OVERRUN: rd_mux = overrun;
      default: begin
        for (int i = 0; i < NUM_SYSREGS; i++)
          if (port_id == 8'(PA_SYSREG0 + i)) rd_mux = snap_q[i];
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!sysreset) begin
      io_data_out <= '0;
      motctl      <= '0;
      dig_q       <= '0;
      dp          <= '0;
      leds        <= '0;
      snap_q      <= '0;
    end else begin
      if (wr.en) begin
        for (int i = 0; i < LED_W; i++)
          if (wr.addr == ((i < 8) ? PA_LED_LO : PA_LED_HI)) leds[i] <= wr.data[i % 8];
        if (wr.addr == PA_MOTCTL) motctl <= wr.data;
        for (int i = 0; i < NUM_DIGITS; i++)
          if (wr.addr == 8'(PA_DIG0 + i)) dig_q[i] <= wr.data[DIGIT_W-1:0];
        if (wr.addr == PA_DP) dp <= wr.data[NUM_DIGITS-1:0];
      end
      // a tripped watchdog parks the motors and overrides any write
      if (wdog_trip) motctl <= '0;
      if (upd_sysregs) snap_q <= sysregs_in;
      io_data_out <= rd_mux;
    end
  end

  assign digits = dig_q;

endmodule

// File: tb/tb_kcpsm_io_hub.sv
// Randomized bench for kcpsm_io_hub against a behavioural port-map model.
// With IO_WATCHDOG_EN defined, runs the watchdog scenario instead of the random phase.
module tb_kcpsm_io_hub;

  localparam int ND = 8;
  localparam int DW = 5;
  localparam int NS = 6;
`ifdef IO_WATCHDOG_EN
  localparam int WD = 16;
`else
  localparam int WD = 1000000;
`endif

  logic          sysclk = 1'b0;
  logic          sysreset;
  logic [5:0]    dbbtns;
  logic [15:0]   switches;
  logic [7:0]    port_id, io_data_in, io_data_out, motctl;
  logic          write_strobe, k_write_strobe, read_strobe;
  logic          interrupt, interrupt_ack, upd_sysregs;
  logic [NS*8-1:0] sysregs_in;
  logic [ND*DW-1:0] digits;
  logic [ND-1:0] dp;
  logic [15:0]   leds;

  always #5 sysclk = ~sysclk;

  kcpsm_io_hub #(.WDOG_CYCLES(WD)) dut (
    .sysclk(sysclk), .sysreset(sysreset), .dbbtns(dbbtns), .switches(switches),
    .port_id(port_id), .io_data_in(io_data_in), .write_strobe(write_strobe),
    .k_write_strobe(k_write_strobe), .read_strobe(read_strobe), .io_data_out(io_data_out),
    .interrupt(interrupt), .interrupt_ack(interrupt_ack), .sysregs_in(sysregs_in),
    .upd_sysregs(upd_sysregs), .motctl(motctl), .digits(digits), .dp(dp), .leds(leds)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit model_on = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  bit         m_pend;
  int         m_ovr;
  logic [7:0] m_snap [NS];
  logic [15:0] m_leds;
  logic [7:0] m_mot, m_rd, m_dp;
  logic [DW-1:0] m_dig [ND];

  function automatic logic [7:0] m_read(input logic [7:0] a);
    int idx;
    idx = int'(a);
    if (idx == 0) return {2'b00, dbbtns};
    if (idx == 1) return switches[7:0];
    if (idx == 2) return switches[15:8];
    if (idx >= 3 && idx < 3 + NS) return m_snap[idx-3];
    if (idx == 14) return {7'b0, m_ovr != 0};
    if (idx == 15) return 8'(m_ovr);
    return 8'h00;
  endfunction

  task automatic model_edge();
    logic [7:0] a;
    int ai;
    bit clr;
    if (!sysreset) begin
      m_pend = 0; m_ovr = 0; m_leds = '0; m_mot = '0; m_rd = '0; m_dp = '0;
      for (int i = 0; i < NS; i++) m_snap[i] = '0;
      for (int i = 0; i < ND; i++) m_dig[i] = '0;
      return;
    end
    m_rd = m_read(port_id);
    clr = 0;
    if (write_strobe || k_write_strobe) begin
      a  = write_strobe ? port_id : {4'h0, port_id[3:0]};
      ai = int'(a);
      if (ai == 1) m_leds[7:0] = io_data_in;
      else if (ai == 2) m_leds[15:8] = io_data_in;
      else if (ai == 9) m_mot = io_data_in;
      else if (ai >= 16 && ai < 16 + ND) m_dig[ai-16] = io_data_in[DW-1:0];
      else if (ai == 24) m_dp = io_data_in;
      else if (ai == 31) clr = 1;
    end
    if (upd_sysregs)
      for (int i = 0; i < NS; i++) m_snap[i] = sysregs_in[8*i +: 8];
    if (!m_pend) begin
      if (upd_sysregs) m_pend = 1;
    end else if (interrupt_ack && !upd_sysregs) begin
      m_pend = 0;
    end else if (upd_sysregs && !interrupt_ack && m_ovr < 255) begin
      m_ovr++;
    end
    if (clr) m_ovr = 0;
  endtask

  task automatic step();
    logic [ND*DW-1:0] ed;
    @(posedge sysclk);
    model_edge();
    #1;
    if (model_on) begin
      for (int i = 0; i < ND; i++) ed[DW*i +: DW] = m_dig[i];
      chk("rd", io_data_out, m_rd);
      chk("irq", interrupt, m_pend);
      chk("motctl", motctl, m_mot);
      chk("leds", leds, m_leds);
      chk("digits", digits, ed);
      chk("dp", dp, m_dp);
    end
  endtask

  task automatic quiet();
    write_strobe = 0; k_write_strobe = 0; upd_sysregs = 0; interrupt_ack = 0;
  endtask

  initial begin
    sysreset = 0; write_strobe = 1; k_write_strobe = 1; read_strobe = 1;
    port_id = 8'h09; io_data_in = 8'hFF; upd_sysregs = 1; interrupt_ack = 0;
    sysregs_in = {16'($urandom), $urandom}; switches = 16'($urandom); dbbtns = 6'($urandom);

    // Reset with strobes active
    repeat (3) step();
    chk("rst_irq", interrupt, 1'b0);
    chk("rst_mot", motctl, 8'h00);
    chk("rst_leds", leds, 16'h0);
    chk("rst_digits", digits, '0);
    chk("rst_rd", io_data_out, 8'h00);
    sysreset = 1; read_strobe = 0; quiet(); port_id = 8'h00;
    step();

    // Basic writes
    write_strobe = 1; port_id = 8'h09; io_data_in = 8'hA5; step();
    chk("mot_wr", motctl, 8'hA5);
    port_id = 8'h10; io_data_in = 8'h1F; step();
    chk("dig0_wr", digits[DW-1:0], 5'h1F);
    write_strobe = 0; k_write_strobe = 1; port_id = 8'h19; io_data_in = 8'h5A; step();
    chk("k_mot_wr", motctl, 8'h5A);
    // both strobes: full address 0x11 (digit1) wins over OUTPUTK 0x01 (leds lo)
    write_strobe = 1; port_id = 8'h11; io_data_in = 8'h07; step();
    chk("both_dig1", digits[DW +: DW], 5'h07);
    chk("both_leds", leds, 16'h0000);
    quiet();

    // Snapshot coherence
    sysregs_in = 48'h665544332211; upd_sysregs = 1; step();
    upd_sysregs = 0;
    for (int i = 0; i < NS; i++) begin
      sysregs_in = {16'($urandom), $urandom};
      port_id = 8'(3 + i); step();
      chk("snap", io_data_out, 8'(8'h11 * (i + 1)));
    end
    chk("snap_irq", interrupt, 1'b1);
    interrupt_ack = 1; step(); interrupt_ack = 0;
    chk("ack_irq", interrupt, 1'b0);

    // Overrun
    upd_sysregs = 1; step();
    chk("irq_set", interrupt, 1'b1);
    step();
    upd_sysregs = 0; port_id = 8'h0F; step();
    chk("ovr_one", io_data_out, 8'h01);
    interrupt_ack = 1; step(); interrupt_ack = 0;
    chk("ovr_ack", interrupt, 1'b0);
    write_strobe = 1; port_id = 8'h1F; step(); write_strobe = 0;

    // Event and ack together while pending
    upd_sysregs = 1; step();
    interrupt_ack = 1; step();
    chk("upd_ack_irq", interrupt, 1'b1);
    quiet(); port_id = 8'h0F; step(); step();
    chk("upd_ack_ovr", io_data_out, 8'h00);
    interrupt_ack = 1; step(); interrupt_ack = 0;

`ifdef IO_WATCHDOG_EN
    model_on = 0;
    write_strobe = 1; port_id = 8'h09; io_data_in = 8'hC3; step(); write_strobe = 0;
    upd_sysregs = 1; step(); upd_sysregs = 0;
    port_id = 8'h0E;
    repeat (20) step();
    chk("wd_mot", motctl, 8'h00);
    chk("wd_status", io_data_out, 8'h02);
    interrupt_ack = 1; step(); interrupt_ack = 0;
    write_strobe = 1; port_id = 8'h1F; step();
    port_id = 8'h09; io_data_in = 8'h3C; step(); write_strobe = 0;
    chk("wd_mot_wr", motctl, 8'h3C);
    port_id = 8'h0E; step(); step();
    chk("wd_clr", io_data_out, 8'h00);
    sysreset = 0; step(); sysreset = 1;
    model_on = 1;
    step();
`else
    // Overrun saturation
    upd_sysregs = 1;
    repeat (262) step();
    upd_sysregs = 0; port_id = 8'h0F; step();
    chk("ovr_sat", io_data_out, 8'hFF);
    port_id = 8'h0E; step();
    chk("status_ovr", io_data_out, 8'h01);
    interrupt_ack = 1; write_strobe = 1; port_id = 8'h1F; step(); quiet();

    // Random phase
    repeat (3000) begin
      sysreset       = ($urandom_range(0, 99) != 0);
      write_strobe   = ($urandom_range(0, 3) == 0);
      k_write_strobe = ($urandom_range(0, 3) == 0);
      read_strobe    = ($urandom_range(0, 3) == 0);
      port_id        = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
      io_data_in     = 8'($urandom);
      upd_sysregs    = ($urandom_range(0, 5) == 0);
      interrupt_ack  = ($urandom_range(0, 3) == 0);
      sysregs_in     = {16'($urandom), $urandom};
      switches       = 16'($urandom);
      dbbtns         = 6'($urandom);
      step();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
